calc_port_responder: RTL and testbench

//   Single-channel responder for the calculator request/response port: captures cmd+operand1,

---
 rtl/calc_pkg.sv | 46 ++++
 rtl/calc_req_fifo.sv | 53 +++++
 rtl/calc_port_responder.sv | 178 +++++++++++++++++
 tb/tb_calc_port_responder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Package  : calc_pkg
// Purpose  : Calculator port encodings, queued request record, latency select.
// Revision : 1.0
// ============================================================================
package calc_pkg;

    localparam int CALC_DATA_W = 32;
    localparam int LAT_W       = 16;

    typedef enum logic [3:0] {
        CMD_NOP = 4'd0,
        CMD_ADD = 4'd1,
        CMD_SUB = 4'd2,
        CMD_SHL = 4'd5,
        CMD_SHR = 4'd6
    } calc_cmd_e;

    typedef enum logic [1:0] {
        RESP_NONE    = 2'b00,
        RESP_OK      = 2'b01,
        RESP_FLOW    = 2'b10,
        RESP_INVALID = 2'b11
    } calc_resp_e;

    // cmd is kept as raw bits so unsupported codes survive the queue and answer INVALID
    typedef struct packed {
        logic [3:0]             cmd;
        logic [CALC_DATA_W-1:0] op1;
        logic [CALC_DATA_W-1:0] op2;
    } calc_req_t;

    function automatic logic [LAT_W-1:0] calc_latency(
        input logic [3:0]       cmd,
        input logic [LAT_W-1:0] add_lat,
        input logic [LAT_W-1:0] shift_lat
    );
        if (cmd == CMD_SHL || cmd == CMD_SHR) begin
            return shift_lat;
        end
        return add_lat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/calc_req_fifo.sv
`default_nettype none
// ============================================================================
// Module   : calc_req_fifo
// Purpose  : Synchronous show-ahead FIFO of calc_req_t; a pop frees a full slot
//            for a same-edge push.
// Revision : 1.0
// ============================================================================
module calc_req_fifo
    import calc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  calc_req_t push_data,
    input  logic      pop,
    output calc_req_t head,
    output logic      full,
    output logic      empty
);

    localparam int PTR_W = $clog2(DEPTH);

    calc_req_t        mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/calc_port_responder.sv
`default_nettype none
// ============================================================================
// Module   : calc_port_responder
// Purpose  : Single-channel calculator responder: two-cycle request capture,
//            request queue, fixed-latency engine, one-cycle response.
//            Optional macro CALC_SHIFT_RANGE_CHECK_EN: shifts with op2 >= 32
//            answer overflow instead of using op2[4:0].
// Revision : 1.0
// ============================================================================
module calc_port_responder
    import calc_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int ADD_LATENCY   = 3,
    parameter int SHIFT_LATENCY = 4,
    parameter int FIFO_DEPTH    = 4,
    parameter int CNT_W         = 8
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic [3:0]        req_cmd_in,
    input  logic [DATA_W-1:0] req_data_in,
    output logic [1:0]        out_resp,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic [CNT_W-1:0]  drop_cnt
);

    typedef enum logic [0:0] {CAP_IDLE = 1'b0, CAP_OP2 = 1'b1} cap_state_e;
    typedef enum logic [1:0] {EX_IDLE = 2'd0, EX_BUSY = 2'd1, EX_RESP = 2'd2} ex_state_e;

    localparam logic [LAT_W-1:0] ADD_LAT   = LAT_W'(ADD_LATENCY);
    localparam logic [LAT_W-1:0] SHIFT_LAT = LAT_W'(SHIFT_LATENCY);

    cap_state_e        cap_state;
    logic [3:0]        cap_cmd;
    logic [DATA_W-1:0] cap_op1;

    logic              push;
    calc_req_t         push_req;
    logic              pop;
    calc_req_t         head;
    logic              fifo_full;
    logic              fifo_empty;

    ex_state_e         ex_state;
    calc_req_t         cur;
    logic [LAT_W-1:0]  lat_cnt;

    calc_resp_e        res_code;
    logic [DATA_W-1:0] res_data;
    logic [DATA_W:0]   sum;

    assign push     = (cap_state == CAP_OP2);
    assign push_req = '{cmd: cap_cmd, op1: cap_op1, op2: req_data_in};
    // Engine takes a new entry whenever it is not mid-countdown, including the response edge
    assign pop      = !fifo_empty && ((ex_state != EX_BUSY) || (lat_cnt == '0));
    assign busy     = (cap_state != CAP_IDLE) || !fifo_empty || (ex_state != EX_IDLE);

    calc_req_fifo #(
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk       (c_clk),
        .rst       (reset),
        .push      (push),
        .push_data (push_req),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            cap_state <= CAP_IDLE;
            cap_cmd   <= '0;
            cap_op1   <= '0;
            drop_cnt  <= '0;
        end else begin
            case (cap_state)
                CAP_IDLE: begin
                    if (req_cmd_in != 4'd0) begin
                        cap_cmd   <= req_cmd_in;
                        cap_op1   <= req_data_in;
                        cap_state <= CAP_OP2;
                    end
                end
                CAP_OP2: begin
                    cap_state <= CAP_IDLE;
                    if (fifo_full && !pop && (drop_cnt != '1)) begin
                        drop_cnt <= drop_cnt + 1'b1;
                    end
                end
                default: cap_state <= CAP_IDLE;
            endcase
        end
    end

    always_comb begin
        res_code = RESP_INVALID;
        res_data = '0;
        sum      = {1'b0, cur.op1} + {1'b0, cur.op2};
        case (cur.cmd)
            CMD_ADD: begin
                if (sum[DATA_W]) begin
                    res_code = RESP_FLOW;
                end else begin
                    res_code = RESP_OK;
                    res_data = sum[DATA_W-1:0];
                end
            end
            CMD_SUB: begin
                if (cur.op1 < cur.op2) begin
                    res_code = RESP_FLOW;
                end else begin
                    res_code = RESP_OK;
                    res_data = cur.op1 - cur.op2;
                end
            end
            CMD_SHL, CMD_SHR: begin
                res_code = RESP_OK;
                res_data = (cur.cmd == CMD_SHL) ? (cur.op1 << cur.op2[4:0])
                                                : (cur.op1 >> cur.op2[4:0]);
`ifdef CALC_SHIFT_RANGE_CHECK_EN
                if (|cur.op2[DATA_W-1:5]) begin
                    res_code = RESP_FLOW;
                    res_data = '0;
                end
`endif
            end
            default: begin
                res_code = RESP_INVALID;
                res_data = '0;
            end
        endcase
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            ex_state <= EX_IDLE;
            cur      <= '0;
            lat_cnt  <= '0;
            out_resp <= RESP_NONE;
            out_data <= '0;
        end else begin
            out_resp <= RESP_NONE;
            out_data <= '0;
            case (ex_state)
                EX_IDLE, EX_RESP: begin
                    if (pop) begin
                        cur      <= head;
                        lat_cnt  <= calc_latency(head.cmd, ADD_LAT, SHIFT_LAT) - LAT_W'(2);
                        ex_state <= EX_BUSY;
                    end else begin
                        ex_state <= EX_IDLE;
                    end
                end
                EX_BUSY: begin
                    if (lat_cnt == '0) begin
                        out_resp <= res_code;
                        out_data <= res_data;
                        if (pop) begin
                            cur     <= head;
                            lat_cnt <= calc_latency(head.cmd, ADD_LAT, SHIFT_LAT) - LAT_W'(2);
                        end else begin
                            ex_state <= EX_RESP;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                default: ex_state <= EX_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_calc_port_responder.sv
`default_nettype none
// Testbench for calc_port_responder: directed vector table plus hand-written
// multi-cycle sequences (queued pair, overflowing burst, mid-compute reset).
module tb_calc_port_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  cmd, cmd_q;
    logic [31:0] data, data_q;
    logic [1:0]  resp, resp_q;
    logic [31:0] odata, odata_q;
    logic        busy, busy_q;
    logic [7:0]  drops, drops_q;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    calc_port_responder dut (
        .c_clk(clk), .reset(reset), .req_cmd_in(cmd), .req_data_in(data),
        .out_resp(resp), .out_data(odata), .busy(busy), .drop_cnt(drops)
    );

    calc_port_responder #(.ADD_LATENCY(16), .FIFO_DEPTH(2)) dut_q (
        .c_clk(clk), .reset(reset), .req_cmd_in(cmd_q), .req_data_in(data_q),
        .out_resp(resp_q), .out_data(odata_q), .busy(busy_q), .drop_cnt(drops_q)
    );

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [1:0]  resp;
        logic [31:0] res;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic run_req(input vec_t v);
        int          seen = 0;
        int          at = -1;
        int          stray = 0;
        logic [1:0]  r = 2'b00;
        logic [31:0] d = 32'h0;
        @(negedge clk); cmd = v.cmd; data = v.op1;
        @(negedge clk); cmd = 4'd0; data = v.op2;
        @(negedge clk); data = 32'h0;
        for (int k = 1; k <= v.lat + 3; k++) begin
            @(negedge clk);
            if (resp != 2'b00) begin
                seen++;
                if (at < 0) begin at = k; r = resp; d = odata; end
            end else if (odata != 32'h0) begin
                stray++;
            end
        end
        check({v.name, " resp"}, 64'(r), 64'(v.resp));
        check({v.name, " data"}, 64'(d), 64'(v.res));
        check({v.name, " latency"}, 64'(at), 64'(v.lat));
        check({v.name, " single pulse"}, 64'(seen), 64'd1);
        check({v.name, " idle data zero"}, 64'(stray), 64'd0);
    endtask

    initial begin
        int bad;
        int nresp;
        int last;
        int fall;
        int rcyc [3];
        logic [31:0] rdat [3];
        logic [1:0]  rcode [3];

        reset = 1'b1; cmd = 4'd0; data = 32'h0; cmd_q = 4'd0; data_q = 32'h0;

        vecs[0]  = '{4'd1, 32'd5,        32'd1,        2'b01, 32'd6,        3, "add 5+1"};
        vecs[1]  = '{4'd1, 32'hFFFFFFFF, 32'd1,        2'b10, 32'd0,        3, "add carry"};
        vecs[2]  = '{4'd1, 32'h7FFFFFFF, 32'h80000000, 2'b01, 32'hFFFFFFFF, 3, "add max no carry"};
        vecs[3]  = '{4'd2, 32'd22,       32'd23,       2'b10, 32'd0,        3, "sub 22-23"};
        vecs[4]  = '{4'd2, 32'd5,        32'd2,        2'b01, 32'd3,        3, "sub 5-2"};
        vecs[5]  = '{4'd2, 32'd5,        32'd5,        2'b01, 32'd0,        3, "sub 5-5"};
        vecs[6]  = '{4'd5, 32'd3,        32'd2,        2'b01, 32'hC,        4, "shl 3,2"};
        vecs[7]  = '{4'd6, 32'hC,        32'd2,        2'b01, 32'd3,        4, "shr C,2"};
        vecs[8]  = '{4'd6, 32'h80000000, 32'd31,       2'b01, 32'd1,        4, "shr by 31"};
`ifdef CALC_SHIFT_RANGE_CHECK_EN
        vecs[9]  = '{4'd5, 32'd1,        32'd33,       2'b10, 32'd0,        4, "shl 1,33"};
`else
        vecs[9]  = '{4'd5, 32'd1,        32'd33,       2'b01, 32'd2,        4, "shl 1,33"};
`endif
        vecs[10] = '{4'd3, 32'd9,        32'd9,        2'b11, 32'd0,        3, "cmd 3 invalid"};
        vecs[11] = '{4'd15, 32'd1,       32'd1,        2'b11, 32'd0,        3, "cmd 15 invalid"};
        vecs[12] = '{4'd4, 32'd1,        32'd2,        2'b11, 32'd0,        3, "cmd 4 invalid"};

        repeat (2) @(negedge clk);
        check("reset resp", 64'(resp), 64'd0);
        check("reset data", 64'(odata), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset drop_cnt", 64'(drops), 64'd0);
        check("reset q busy", 64'(busy_q), 64'd0);
        check("reset q drop_cnt", 64'(drops_q), 64'd0);
        reset = 1'b0;

        foreach (vecs[i]) run_req(vecs[i]);

        // cmd 0 never starts a request
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); cmd = 4'd0; data = $urandom;
            if (busy || resp != 2'b00) bad++;
        end
        @(negedge clk);
        if (busy || resp != 2'b00) bad++;
        check("cmd0 quiet", 64'(bad), 64'd0);

        // SHL then ADD back to back: second pops on first's response edge
        nresp = 0;
        for (int c = 0; c <= 12; c++) begin
            if (c > 0 && resp != 2'b00) begin
                if (nresp < 2) begin rcyc[nresp] = c; rdat[nresp] = odata; end
                nresp++;
            end
            case (c + 1)
                1: begin cmd = 4'd5; data = 32'd3;  end
                2: begin cmd = 4'd0; data = 32'd2;  end
                3: begin cmd = 4'd1; data = 32'd10; end
                4: begin cmd = 4'd0; data = 32'd20; end
                default: begin cmd = 4'd0; data = 32'd0; end
            endcase
            @(negedge clk);
        end
        check("pair count", 64'(nresp), 64'd2);
        check("pair shl edge", 64'(rcyc[0]), 64'd6);
        check("pair shl data", 64'(rdat[0]), 64'hC);
        check("pair add edge", 64'(rcyc[1]), 64'd8);
        check("pair add data", 64'(rdat[1]), 64'd30);

        // Five back-to-back ADDs into a 2-deep queue behind a 16-edge engine
        nresp = 0; last = -1; fall = -1;
        for (int c = 0; c <= 60; c++) begin
            if (c > 0) begin
                if (resp_q != 2'b00) begin
                    if (nresp < 3) begin
                        rcyc[nresp] = c; rdat[nresp] = odata_q; rcode[nresp] = resp_q;
                    end
                    nresp++;
                    last = c;
                end
                if (last > 0 && fall < 0 && c > last && !busy_q) fall = c;
            end
            if (c + 1 <= 10) begin
                if ((c + 1) % 2 == 1) begin cmd_q = 4'd1; data_q = 32'((c + 2) / 2); end
                else begin cmd_q = 4'd0; data_q = 32'(100 * ((c + 1) / 2)); end
            end else begin
                cmd_q = 4'd0; data_q = 32'd0;
            end
            @(negedge clk);
        end
        check("burst response count", 64'(nresp), 64'd3);
        check("burst drop_cnt", 64'(drops_q), 64'd2);
        check("burst r1 edge", 64'(rcyc[0]), 64'd18);
        check("burst r2 edge", 64'(rcyc[1]), 64'd33);
        check("burst r3 edge", 64'(rcyc[2]), 64'd48);
        check("burst r1 data", 64'(rdat[0]), 64'd101);
        check("burst r2 data", 64'(rdat[1]), 64'd202);
        check("burst r3 data", 64'(rdat[2]), 64'd303);
        check("burst r3 code", 64'(rcode[2]), 64'd1);
        check("burst busy fall", 64'(fall), 64'(last + 1));

        // Reset pulsed while an ADD is counting down
        @(negedge clk); cmd = 4'd1; data = 32'd5;
        @(negedge clk); cmd = 4'd0; data = 32'd1;
        @(negedge clk); data = 32'd0;
        @(negedge clk);
        check("pre-reset busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (resp != 2'b00 || busy) bad++;
        end
        check("reset mid compute quiet", 64'(bad), 64'd0);
        run_req(vecs[0]);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
